// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one 32-bit adder, registered tagged result.
// Define ADDER_ARB_SUB_EN to build the optional subtract path.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_sub,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_sum,
  output logic              resp_cout
);

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  nxt_ptr;
  logic [NREQ-1:0] gnt_oh;
  logic            found;
  logic            accept;
  logic            grant;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic            cin_sel;
  logic [31:0]     b_op;
  logic            cin_op;
  logic [32:0]     sum33;

  // Priority search rotated to start at rr_ptr.
  always_comb begin
    gnt_oh = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(rr_ptr) + k) % NREQ) == i) begin
          found     = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_id    = IDW'(i);
        end
      end
    end
  end

  assign accept    = !resp_valid || resp_ready;
  assign grant     = clear_n && accept && found;
  assign req_ready = grant ? gnt_oh : '0;
  assign nxt_ptr   = (int'(gnt_id) == NREQ-1) ? '0
                                             : gnt_id + IDW'(1);

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        a_sel   = req_a[32*i +: 32];
        b_sel   = req_b[32*i +: 32];
        cin_sel = req_cin[i];
      end
    end
  end

`ifdef ADDER_ARB_SUB_EN
  logic sub_sel;

  always_comb begin
    sub_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) sub_sel = req_sub[i];
    end
  end

  assign b_op   = sub_sel ? ~b_sel : b_sel;
  assign cin_op = sub_sel ? 1'b1 : cin_sel;
`else
  logic unused_sub;

  assign unused_sub = ^req_sub;
  assign b_op       = b_sel;
  assign cin_op     = cin_sel;
`endif

  assign sum33 = {1'b0, a_sel} + {1'b0, b_op} + {32'b0, cin_op};

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      rr_ptr     <= '0;
    end else if (grant) begin
      resp_valid <= 1'b1;
      resp_id    <= gnt_id;
      resp_sum   <= sum33[31:0];
      resp_cout  <= sum33[32];
      rr_ptr     <= nxt_ptr;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed scenario bench for adder_arbiter.
// Subtract scenario runs only when ADDER_ARB_SUB_EN is defined.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              clear_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_sub;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_sum;
  logic              resp_cout;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .req_sub    (req_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout)
  );

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic cin,
                        input logic sub);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_cin[i]        = cin;
    req_sub[i]        = sub;
  endtask

  task automatic do_reset();
    @(negedge clock);
    req_valid = '0;
    clear_n   = 1'b0;
    @(negedge clock);
    clear_n   = 1'b1;
  endtask

  task automatic test_reset();
    logic [35:0] exp;
    clear_n    = 1'b0;
    req_valid  = 4'hF | 4'($urandom);
    req_a      = {$urandom, $urandom, $urandom, $urandom};
    req_b      = {$urandom, $urandom, $urandom, $urandom};
    req_cin    = 4'($urandom);
    req_sub    = 4'($urandom);
    resp_ready = 1'($urandom);
    repeat (3) @(negedge clock);
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== 36'b0) begin
      fails++;
      $display("FAIL reset_resp got=%h want=0",
               {resp_valid, resp_id, resp_sum, resp_cout});
    end
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
    clear_n    = 1'b1;
    req_valid  = 4'b1010;
    set_op(1, 32'd100, 32'd23, 1'b1, 1'b0);
    set_op(3, 32'd9, 32'd9, 1'b0, 1'b0);
    resp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0010) begin
      fails++;
      $display("FAIL first_grant got=%b want=0010", req_ready);
    end
    @(posedge clock); #1;
    exp = {1'b1, 2'd1, 32'd124, 1'b0};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL first_resp got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    req_valid = '0;
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL idle_ready got=%b want=0000", req_ready);
    end
    @(posedge clock); #1;
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL drain got=%b want=0", resp_valid);
    end
  endtask

  task automatic test_single();
    logic [35:0] exp;
    @(negedge clock);
    req_valid = 4'b0100;
    set_op(2, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++;
      $display("FAIL single_ready got=%b want=0100", req_ready);
    end
    @(posedge clock); #1;
    exp = {1'b1, 2'd2, 32'h0, 1'b1};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL single_resp got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    req_valid = 4'b0001;
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_ready got=%b want=0001", req_ready);
    end
    @(posedge clock); #1;
    exp = {1'b1, 2'd0, 32'hFFFF_FFFF, 1'b1};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL max_resp got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    req_valid = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_round_robin();
    logic [31:0] sums [4];
    logic [3:0]  exp_rdy;
    logic [35:0] exp;
    sums[0] = 32'h1001;
    sums[1] = 32'h2003;
    sums[2] = 32'h3003;
    sums[3] = 32'h4005;
    do_reset();
    set_op(0, 32'h1000, 32'd1, 1'b0, 1'b0);
    set_op(1, 32'h2000, 32'd2, 1'b1, 1'b0);
    set_op(2, 32'h3000, 32'd3, 1'b0, 1'b0);
    set_op(3, 32'h4000, 32'd4, 1'b1, 1'b0);
    req_valid  = 4'hF;
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clock);
      #1;
      exp_rdy = 4'(1 << (k % 4));
      tests++;
      if (req_ready !== exp_rdy) begin
        fails++;
        $display("FAIL rr_ready[%0d] got=%b want=%b",
                 k, req_ready, exp_rdy);
      end
      @(posedge clock); #1;
      exp = {1'b1, 2'(k % 4), sums[k % 4], 1'b0};
      tests++;
      if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
        fails++;
        $display("FAIL rr_resp[%0d] got=%h want=%h", k,
                 {resp_valid, resp_id, resp_sum, resp_cout}, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] exp;
    exp = {1'b1, 2'd3, 32'h4005, 1'b0};
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      resp_ready = 1'b0;
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin
        fails++;
        $display("FAIL bp_ready[%0d] got=%b want=0000", c, req_ready);
      end
      @(posedge clock); #1;
      tests++;
      if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
        fails++;
        $display("FAIL bp_hold[%0d] got=%h want=%h", c,
                 {resp_valid, resp_id, resp_sum, resp_cout}, exp);
      end
    end
    @(negedge clock);
    resp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL bp_release got=%b want=0001", req_ready);
    end
    @(posedge clock); #1;
    exp = {1'b1, 2'd0, 32'h1001, 1'b0};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL bp_resp got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [35:0] exp;
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== 36'b0) begin
      fails++;
      $display("FAIL midrst_resp got=%h want=0",
               {resp_valid, resp_id, resp_sum, resp_cout});
    end
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_ready got=%b want=0000", req_ready);
    end
    @(negedge clock);
    clear_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_ptr got=%b want=0001", req_ready);
    end
    @(posedge clock); #1;
    exp = {1'b1, 2'd0, 32'h1001, 1'b0};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL midrst_resp2 got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    req_valid = '0;
    @(posedge clock); #1;
  endtask

`ifdef ADDER_ARB_SUB_EN
  task automatic test_sub();
    logic [35:0] exp;
    @(negedge clock);
    resp_ready = 1'b1;
    req_valid  = 4'b0001;
    set_op(0, 32'd5, 32'd7, 1'b1, 1'b1);
    @(posedge clock); #1;
    exp = {1'b1, 2'd0, 32'hFFFF_FFFE, 1'b0};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL sub_borrow got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    set_op(0, 32'd7, 32'd5, 1'b0, 1'b1);
    @(posedge clock); #1;
    exp = {1'b1, 2'd0, 32'd2, 1'b1};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL sub_noborrow got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    set_op(0, 32'd7, 32'd5, 1'b0, 1'b0);
    @(posedge clock); #1;
    exp = {1'b1, 2'd0, 32'd12, 1'b0};
    tests++;
    if ({resp_valid, resp_id, resp_sum, resp_cout} !== exp) begin
      fails++;
      $display("FAIL sub_off got=%h want=%h",
               {resp_valid, resp_id, resp_sum, resp_cout}, exp);
    end
    @(negedge clock);
    req_valid = '0;
    @(posedge clock); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
`ifdef ADDER_ARB_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
